// File: rtl/cam_lut_reg_if.sv
// Register-bus adapter in front of the CAM/LUT table ports: stages entry fields in shadow
// registers and turns WR_IDX/RD_IDX writes into table handshakes with a bounded wait.
module cam_lut_reg_if #(
   parameter int unsigned CMP_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH     = 3,
   parameter int unsigned LUT_DEPTH_BITS = 4,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reg_req_i,
   input  logic                      reg_rd_wr_l_i,
   input  logic [2:0]                reg_addr_i,
   input  logic [31:0]               reg_wr_data_i,
   output logic                      reg_ack_o,
   output logic [31:0]               reg_rd_data_o,
   output logic [LUT_DEPTH_BITS-1:0] rd_addr_o,
   output logic                      rd_req_o,
   input  logic [DATA_WIDTH-1:0]     rd_data_i,
   input  logic [CMP_WIDTH-1:0]      rd_cmp_data_i,
   input  logic [CMP_WIDTH-1:0]      rd_cmp_dmask_i,
   input  logic                      rd_ack_i,
   output logic [LUT_DEPTH_BITS-1:0] wr_addr_o,
   output logic                      wr_req_o,
   output logic [DATA_WIDTH-1:0]     wr_data_o,
   output logic [CMP_WIDTH-1:0]      wr_cmp_data_o,
   output logic [CMP_WIDTH-1:0]      wr_cmp_dmask_o,
   input  logic                      wr_ack_i
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StWrWait, StRdWait, StDone} state_e;

   state_e                    state_q, state_d;
   logic                      reg_ack_q, reg_ack_d;
   logic [31:0]               reg_rd_data_q, reg_rd_data_d;
   logic [LUT_DEPTH_BITS-1:0] rd_addr_q, rd_addr_d;
   logic [LUT_DEPTH_BITS-1:0] wr_addr_q, wr_addr_d;
   logic                      rd_req_q, rd_req_d;
   logic                      wr_req_q, wr_req_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic [CMP_WIDTH-1:0]      cmp_q, cmp_d;
   logic [CMP_WIDTH-1:0]      mask_q, mask_d;
   logic                      timed_out_q, timed_out_d;
   logic [7:0]                to_cnt_q, to_cnt_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [31:0]               read_word;

   always_comb begin
      read_word = 32'h0;
      case (reg_addr_i)
         3'd0:    read_word = 32'(data_q);
         3'd1:    read_word = 32'(cmp_q);
         3'd2:    read_word = 32'(mask_q);
         3'd3:    read_word = 32'(wr_addr_q);
         3'd4:    read_word = 32'(rd_addr_q);
         3'd5:    read_word = {16'h0, to_cnt_q, 7'h0, timed_out_q};
         default: read_word = 32'h0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      reg_ack_d     = 1'b0;
      reg_rd_data_d = reg_rd_data_q;
      rd_addr_d     = rd_addr_q;
      wr_addr_d     = wr_addr_q;
      rd_req_d      = rd_req_q;
      wr_req_d      = wr_req_q;
      data_d        = data_q;
      cmp_d         = cmp_q;
      mask_d        = mask_q;
      timed_out_d   = timed_out_q;
      to_cnt_d      = to_cnt_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         StIdle: begin
            // The cycle reg_ack is high still sees the master's req; it belongs to the old access.
            if (reg_req_i && !reg_ack_q) begin
               state_d = StDone;
               if (reg_rd_wr_l_i) begin
                  reg_rd_data_d = read_word;
               end else begin
                  case (reg_addr_i)
                     3'd0: data_d = reg_wr_data_i[DATA_WIDTH-1:0];
                     3'd1: cmp_d  = reg_wr_data_i[CMP_WIDTH-1:0];
                     3'd2: mask_d = reg_wr_data_i[CMP_WIDTH-1:0];
                     3'd3: begin
                        wr_addr_d = reg_wr_data_i[LUT_DEPTH_BITS-1:0];
                        wr_req_d  = 1'b1;
                        cnt_d     = 8'h0;
                        state_d   = StWrWait;
                     end
                     3'd4: begin
                        rd_addr_d = reg_wr_data_i[LUT_DEPTH_BITS-1:0];
                        rd_req_d  = 1'b1;
                        cnt_d     = 8'h0;
                        state_d   = StRdWait;
                     end
                     default: ;
                  endcase
               end
            end
         end
         StWrWait: begin
            if (wr_ack_i) begin
               wr_req_d    = 1'b0;
               timed_out_d = 1'b0;
               state_d     = StDone;
            end else if (cnt_q == TimeoutLast) begin
               wr_req_d    = 1'b0;
               timed_out_d = 1'b1;
               if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
               state_d     = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StRdWait: begin
            if (rd_ack_i) begin
               data_d      = rd_data_i;
               cmp_d       = rd_cmp_data_i;
               mask_d      = rd_cmp_dmask_i;
               rd_req_d    = 1'b0;
               timed_out_d = 1'b0;
               state_d     = StDone;
            end else if (cnt_q == TimeoutLast) begin
               rd_req_d    = 1'b0;
               timed_out_d = 1'b1;
               if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
               state_d     = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone: begin
            reg_ack_d = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         reg_ack_q     <= 1'b0;
         reg_rd_data_q <= 32'h0;
         rd_addr_q     <= '0;
         wr_addr_q     <= '0;
         rd_req_q      <= 1'b0;
         wr_req_q      <= 1'b0;
         data_q        <= '0;
         cmp_q         <= '0;
         mask_q        <= '0;
         timed_out_q   <= 1'b0;
         to_cnt_q      <= 8'h0;
         cnt_q         <= 8'h0;
      end else begin
         state_q       <= state_d;
         reg_ack_q     <= reg_ack_d;
         reg_rd_data_q <= reg_rd_data_d;
         rd_addr_q     <= rd_addr_d;
         wr_addr_q     <= wr_addr_d;
         rd_req_q      <= rd_req_d;
         wr_req_q      <= wr_req_d;
         data_q        <= data_d;
         cmp_q         <= cmp_d;
         mask_q        <= mask_d;
         timed_out_q   <= timed_out_d;
         to_cnt_q      <= to_cnt_d;
         cnt_q         <= cnt_d;
      end
   end

   assign reg_ack_o      = reg_ack_q;
   assign reg_rd_data_o  = reg_rd_data_q;
   assign rd_addr_o      = rd_addr_q;
   assign rd_req_o       = rd_req_q;
   assign wr_addr_o      = wr_addr_q;
   assign wr_req_o       = wr_req_q;
   assign wr_data_o      = data_q;
   assign wr_cmp_data_o  = cmp_q;
   assign wr_cmp_dmask_o = mask_q;

endmodule

// File: tb/tb_cam_lut_reg_if.sv
// Bench for cam_lut_reg_if: transaction-level register/table model plus a table responder,
// checked every cycle on the falling edge, with directed scenarios then random traffic.
module tb_cam_lut_reg_if;

   localparam int unsigned CW    = 32;
   localparam int unsigned DW    = 3;
   localparam int unsigned LB    = 4;
   localparam int unsigned TO    = 255;
   localparam int unsigned DEPTH = 1 << LB;
   localparam logic [31:0] DMASK = 32'((64'd1 << DW) - 64'd1);
   localparam logic [31:0] CMASK = 32'((64'd1 << CW) - 64'd1);
   localparam logic [31:0] IMASK = 32'((64'd1 << LB) - 64'd1);

   logic          clk = 1'b0;
   logic          reset;
   logic          reg_req, reg_rd_wr_l, reg_ack;
   logic [2:0]    reg_addr;
   logic [31:0]   reg_wr_data, reg_rd_data;
   logic [LB-1:0] rd_addr, wr_addr;
   logic          rd_req, wr_req, rd_ack, wr_ack;
   logic [DW-1:0] rd_data, wr_data;
   logic [CW-1:0] rd_cmp_data, rd_cmp_dmask, wr_cmp_data, wr_cmp_dmask;

   cam_lut_reg_if #(
      .CMP_WIDTH(CW), .DATA_WIDTH(DW), .LUT_DEPTH_BITS(LB), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .reg_req_i(reg_req), .reg_rd_wr_l_i(reg_rd_wr_l), .reg_addr_i(reg_addr),
      .reg_wr_data_i(reg_wr_data), .reg_ack_o(reg_ack), .reg_rd_data_o(reg_rd_data),
      .rd_addr_o(rd_addr), .rd_req_o(rd_req), .rd_data_i(rd_data),
      .rd_cmp_data_i(rd_cmp_data), .rd_cmp_dmask_i(rd_cmp_dmask), .rd_ack_i(rd_ack),
      .wr_addr_o(wr_addr), .wr_req_o(wr_req), .wr_data_o(wr_data),
      .wr_cmp_data_o(wr_cmp_data), .wr_cmp_dmask_o(wr_cmp_dmask), .wr_ack_i(wr_ack)
   );

   always #5 clk = ~clk;

   // Model of software-visible state and of the table contents.
   logic [31:0] m_data, m_cmp, m_mask, m_wr_idx, m_rd_idx;
   int          m_to, m_cnt;
   logic [31:0] tbl_d [DEPTH];
   logic [31:0] tbl_c [DEPTH];
   logic [31:0] tbl_m [DEPTH];

   bit          exp_ack, exp_wr_req, exp_rd_req, exp_rd_valid, checking, inject_stray;
   logic [31:0] exp_rd_data;
   int          n_chk = 0, n_fail = 0, ack_cnt = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input int a);
      case (a)
         0:       return m_data;
         1:       return m_cmp;
         2:       return m_mask;
         3:       return m_wr_idx;
         4:       return m_rd_idx;
         5:       return 32'(m_cnt * 256 + m_to);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_data = 0; m_cmp = 0; m_mask = 0; m_wr_idx = 0; m_rd_idx = 0; m_to = 0; m_cnt = 0;
      exp_ack = 0; exp_wr_req = 0; exp_rd_req = 0; exp_rd_valid = 0; exp_rd_data = 0;
   endtask

   function automatic bit stray();
      return inject_stray && ($urandom_range(0, 3) == 0);
   endfunction

   // ack_at: wait-state edge (1-based) on which the table acks; 0 = never.
   task automatic access(input bit rd, input logic [2:0] a, input logic [31:0] d,
                         input int ack_at, input bit hold, output logic [31:0] rdata);
      wr_ack = 0; rd_ack = 0;
      reg_req = 1; reg_rd_wr_l = rd; reg_addr = a; reg_wr_data = d;
      @(posedge clk); #1;
      exp_rd_valid = rd;
      if (rd) exp_rd_data = model_read(int'(a));
      else begin
         case (a)
            3'd0: m_data = d & DMASK;
            3'd1: m_cmp  = d & CMASK;
            3'd2: m_mask = d & CMASK;
            3'd3: begin m_wr_idx = d & IMASK; exp_wr_req = 1; end
            3'd4: begin m_rd_idx = d & IMASK; exp_rd_req = 1; end
            default: ;
         endcase
      end
      if (!rd && (a == 3'd3 || a == 3'd4)) begin
         for (int k = 1; k <= int'(TO); k++) begin
            bit acked;
            acked = (k == ack_at);
            rd_data = DW'($urandom); rd_cmp_data = CW'($urandom); rd_cmp_dmask = CW'($urandom);
            if (a == 3'd3) begin
               wr_ack = acked; rd_ack = stray();
            end else begin
               rd_ack = acked; wr_ack = stray();
               if (acked) begin
                  rd_data      = DW'(tbl_d[m_rd_idx[LB-1:0]]);
                  rd_cmp_data  = CW'(tbl_c[m_rd_idx[LB-1:0]]);
                  rd_cmp_dmask = CW'(tbl_m[m_rd_idx[LB-1:0]]);
               end
            end
            @(posedge clk); #1;
            wr_ack = 0; rd_ack = 0;
            if (acked) begin
               m_to = 0;
               if (a == 3'd3) begin
                  tbl_d[m_wr_idx[LB-1:0]] = m_data;
                  tbl_c[m_wr_idx[LB-1:0]] = m_cmp;
                  tbl_m[m_wr_idx[LB-1:0]] = m_mask;
               end else begin
                  m_data = tbl_d[m_rd_idx[LB-1:0]];
                  m_cmp  = tbl_c[m_rd_idx[LB-1:0]];
                  m_mask = tbl_m[m_rd_idx[LB-1:0]];
               end
               break;
            end else if (k == int'(TO)) begin
               m_to = 1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         exp_wr_req = 0; exp_rd_req = 0;
      end
      @(posedge clk); #1;
      exp_ack = 1;
      rdata = reg_rd_data;
      if (!hold) reg_req = 0;
      @(posedge clk); #1;
      exp_ack = 0;
   endtask

   always @(negedge clk) begin
      if (checking) begin
         if (reg_ack) ack_cnt++;
         chk("reg_ack", 32'(reg_ack), 32'(exp_ack));
         chk("wr_req", 32'(wr_req), 32'(exp_wr_req));
         chk("rd_req", 32'(rd_req), 32'(exp_rd_req));
         chk("one_req", 32'(rd_req & wr_req), 32'h0);
         if (exp_wr_req) begin
            chk("wr_addr", 32'(wr_addr), m_wr_idx);
            chk("wr_data", 32'(wr_data), m_data);
            chk("wr_cmp_data", 32'(wr_cmp_data), m_cmp);
            chk("wr_cmp_dmask", 32'(wr_cmp_dmask), m_mask);
         end
         if (exp_rd_req) chk("rd_addr", 32'(rd_addr), m_rd_idx);
         if (exp_ack && exp_rd_valid) chk("reg_rd_data", reg_rd_data, exp_rd_data);
      end
   end

   initial begin
      logic [31:0] r, r2;
      int          acks0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         tbl_d[i] = $urandom & DMASK; tbl_c[i] = $urandom; tbl_m[i] = $urandom;
      end
      reset = 1; reg_req = 0; reg_rd_wr_l = 0; reg_addr = 0; reg_wr_data = 0;
      rd_ack = 0; wr_ack = 0; rd_data = 0; rd_cmp_data = 0; rd_cmp_dmask = 0;
      inject_stray = 0; checking = 0;
      model_reset();
      @(posedge clk); #1;
      checking = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      chk("rst_rd_data", reg_rd_data, 32'h0);
      chk("rst_rd_addr", 32'(rd_addr), 32'h0);
      chk("rst_wr_addr", 32'(wr_addr), 32'h0);

      // Staged write, table acks on the third wait edge.
      access(0, 3'd0, 32'h5, 0, 0, r);
      access(0, 3'd1, 32'hC0A80001, 0, 0, r);
      access(0, 3'd2, 32'h000000FF, 0, 0, r);
      fork
         access(0, 3'd3, 32'd7, 3, 0, r);
         begin
            @(posedge clk); #2;
            chk("t1_wr_req", 32'(wr_req), 32'h1);
            chk("t1_wr_addr", 32'(wr_addr), 32'd7);
            chk("t1_wr_data", 32'(wr_data), 32'h5);
            chk("t1_wr_cmp", 32'(wr_cmp_data), 32'hC0A80001);
            chk("t1_wr_mask", 32'(wr_cmp_dmask), 32'hFF);
         end
      join
      access(1, 3'd5, 32'h0, 0, 0, r);
      chk("t1_status", r, 32'h0);

      // Table stalled behind lookups for 40 cycles.
      acks0 = ack_cnt;
      access(0, 3'd3, 32'd9, 41, 0, r);
      chk("t2_one_ack", 32'(ack_cnt - acks0), 32'd1);
      access(1, 3'd5, 32'h0, 0, 0, r);
      chk("t2_status", r, 32'h0);

      // Read-back of entry 7.
      access(0, 3'd4, 32'd7, 2, 0, r);
      access(1, 3'd0, 32'h0, 0, 0, r);
      chk("t3_data", r, 32'h5);
      access(1, 3'd1, 32'h0, 0, 0, r);
      chk("t3_cmp", r, 32'hC0A80001);
      access(1, 3'd2, 32'h0, 0, 0, r);
      chk("t3_mask", r, 32'hFF);

      // Timeouts, with a late wr_ack in between.
      access(0, 3'd3, 32'd2, 0, 0, r);
      wr_ack = 1; @(posedge clk); #1; wr_ack = 0;
      access(1, 3'd5, 32'h0, 0, 0, r);
      chk("t4_status1", r, 32'h0101);
      access(0, 3'd3, 32'd2, 0, 0, r);
      access(1, 3'd5, 32'h0, 0, 0, r);
      chk("t4_status2", r, 32'h0201);

      // reg_req held across back-to-back reads.
      acks0 = ack_cnt;
      access(1, 3'd5, 32'h0, 0, 1, r);
      access(1, 3'd6, 32'h0, 0, 0, r2);
      chk("t6_status", r, 32'h0201);
      chk("t6_addr6", r2, 32'h0);
      chk("t6_acks", 32'(ack_cnt - acks0), 32'd2);

      // Reset while the table read is outstanding.
      reg_req = 1; reg_rd_wr_l = 0; reg_addr = 3'd4; reg_wr_data = 32'd5;
      @(posedge clk); #1;
      m_rd_idx = 32'd5; exp_rd_req = 1; reg_req = 0;
      repeat (5) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      model_reset();
      reset = 0;
      chk("t5_rd_req", 32'(rd_req), 32'h0);
      chk("t5_reg_ack", 32'(reg_ack), 32'h0);
      for (int a = 0; a < 6; a++) begin
         access(1, 3'(a), 32'h0, 0, 0, r);
         chk("t5_reg_zero", r, 32'h0);
      end

      // Random traffic with stray acks.
      inject_stray = 1;
      for (int n = 0; n < 150; n++) begin
         bit h;
         int ack_at;
         h = ($urandom_range(0, 3) == 0);
         ack_at = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12));
         access(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, ack_at, h, r);
         if (!h) begin
            repeat ($urandom_range(0, 2)) begin
               wr_ack = stray(); rd_ack = stray();
               @(posedge clk); #1;
               wr_ack = 0; rd_ack = 0;
            end
         end
      end
      reg_req = 0;
      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
